// File: rtl/pipeline_cmd_issuer_pkg.sv
// Shared protocol definitions for the pipeline command issuer: opcodes,
// response codes, FSM states and per-opcode payload helpers.
package pipeline_cmd_issuer_pkg;

  localparam int BLOCK_INSTR_WIDTH    = 32;
  localparam int BLOCK_REG_ADDR_WIDTH = 4;
  localparam int IB                   = (BLOCK_INSTR_WIDTH + 7) / 8;
  // Wide enough for the longest frame (blk + instr bytes) and for 4-byte payloads
  localparam int SHIFT_W              = (((IB + 1) * 8) > 32) ? ((IB + 1) * 8) : 32;

  localparam logic [7:0] OP_INSTR_WR = 8'h01;
  localparam logic [7:0] OP_REG_WR   = 8'h02;
  localparam logic [7:0] OP_REG_UPD  = 8'h03;
  localparam logic [7:0] OP_COMMIT   = 8'h04;
  localparam logic [7:0] OP_ALLOC    = 8'h05;
  localparam logic [7:0] OP_FRESET   = 8'h06;

  localparam logic [7:0] RESP_OK_BASE  = 8'hA0;
  localparam logic [7:0] RESP_BAD_OP   = 8'hE0;
  localparam logic [7:0] RESP_BAD_ADDR = 8'hE1;
  localparam logic [7:0] RESP_TIMEOUT  = 8'hE2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PAYLOAD = 3'd1,
    ST_CHECK   = 3'd2,
    ST_ISSUE   = 3'd3,
    ST_WAIT    = 3'd4,
    ST_RESPOND = 3'd5
  } state_e;

  function automatic logic [3:0] payload_len(input logic [7:0] op);
    case (op)
      OP_INSTR_WR:                   payload_len = 4'(IB + 1);
      OP_REG_WR, OP_REG_UPD, OP_ALLOC: payload_len = 4'd4;
      default:                       payload_len = 4'd0;
    endcase
  endfunction

  function automatic logic op_known(input logic [7:0] op);
    return (op >= OP_INSTR_WR) && (op <= OP_FRESET);
  endfunction

  function automatic logic op_needs_ack(input logic [7:0] op);
    return (op == OP_INSTR_WR) || (op == OP_REG_WR) || (op == OP_REG_UPD) || (op == OP_FRESET);
  endfunction

endpackage

// File: rtl/pipeline_cmd_issuer_byte_assembler.sv
// Shifts accepted payload bytes MSB-first into a wide register and counts
// how many bytes of the current frame have arrived.
module pipeline_cmd_issuer_byte_assembler
  import pipeline_cmd_issuer_pkg::*;
#(
  parameter int W = SHIFT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_shift,
  input  logic [7:0]   i_byte,
  output logic [W-1:0] o_data,
  output logic [3:0]   o_count
);

  logic [W-1:0] r_data;
  logic [3:0]   r_count;

  // Payload shift register and byte counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_count <= 4'd0;
    end else if (i_clear) begin
      r_data  <= '0;
      r_count <= 4'd0;
    end else if (i_shift) begin
      r_data  <= {r_data[W-9:0], i_byte};
      r_count <= r_count + 4'd1;
    end else begin
      r_data  <= r_data;
      r_count <= r_count;
    end
  end

  assign o_data  = r_data;
  assign o_count = r_count;

endmodule

// File: rtl/pipeline_cmd_issuer.sv
// Host command initiator for the dsp_pipeline configuration interface:
// frames bytes into commands, strobes the pipeline, waits for acks, replies.
module pipeline_cmd_issuer
  import pipeline_cmd_issuer_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int N_BLOCKS    = 256,
  parameter int ACK_TIMEOUT = 1023,
  localparam int BLK_W      = $clog2(N_BLOCKS),
  localparam int TMR_W      = $clog2(ACK_TIMEOUT + 1)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [7:0]                            in_byte,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [7:0]                            resp_byte,
  output logic                                  resp_valid,
  input  logic                                  resp_ready,
  output logic [BLK_W-1:0]                      block_target,
  output logic [BLK_W+BLOCK_REG_ADDR_WIDTH-1:0] reg_target,
  output logic [BLOCK_INSTR_WIDTH-1:0]          instr_val,
  output logic [DATA_WIDTH-1:0]                 ctrl_data,
  output logic [2*DATA_WIDTH-1:0]               buf_init_delay,
  output logic                                  instr_write,
  output logic                                  reg_write,
  output logic                                  reg_update,
  output logic                                  reg_writes_commit,
  output logic                                  alloc_delay,
  output logic                                  full_reset,
  input  logic                                  instr_write_ack,
  input  logic                                  reg_write_ack,
  input  logic                                  resetting,
  output logic                                  busy,
  output logic [31:0]                           cmd_count
);

  state_e                                r_state, w_next;
  logic [7:0]                            r_op;
  logic [TMR_W-1:0]                      r_timer;
  logic                                  r_seen_high;
  logic                                  r_in_ready, r_busy, r_resp_valid;
  logic [7:0]                            r_resp_byte;
  logic [31:0]                           r_cmd_count;
  logic                                  r_instr_write, r_reg_write, r_reg_update;
  logic                                  r_commit, r_alloc, r_freset;
  logic [BLK_W-1:0]                      r_block_target;
  logic [BLK_W+BLOCK_REG_ADDR_WIDTH-1:0] r_reg_target;
  logic [BLOCK_INSTR_WIDTH-1:0]          r_instr_val;
  logic [DATA_WIDTH-1:0]                 r_ctrl_data;
  logic [2*DATA_WIDTH-1:0]               r_delay;

  logic [SHIFT_W-1:0] w_sh;
  logic [3:0]         w_count;
  logic               w_in_fire;
  logic [7:0]         w_blk_byte, w_reg_addr;
  logic               w_check_ok, w_ack_done, w_timeout, w_issue;
  logic               w_resp_load, w_resp_ok;
  logic [7:0]         w_resp_code;

  assign w_in_fire  = in_valid && r_in_ready;
  assign w_reg_addr = w_sh[23:16];
  assign w_blk_byte = (r_op == OP_INSTR_WR) ? w_sh[IB*8 +: 8] : w_sh[31:24];

  pipeline_cmd_issuer_byte_assembler #(.W(SHIFT_W)) u_asm (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_in_fire && (r_state == ST_IDLE)),
    .i_shift (w_in_fire && (r_state == ST_PAYLOAD)),
    .i_byte  (in_byte),
    .o_data  (w_sh),
    .o_count (w_count)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_in_fire)                   w_next = ST_IDLE;
        else if (!op_known(in_byte))      w_next = ST_RESPOND;
        else if (payload_len(in_byte) == 4'd0) w_next = ST_CHECK;
        else                              w_next = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (w_in_fire && ((w_count + 4'd1) == payload_len(r_op))) w_next = ST_CHECK;
        else                                                      w_next = ST_PAYLOAD;
      end
      ST_CHECK: w_next = w_check_ok ? ST_ISSUE : ST_RESPOND;
      ST_ISSUE, ST_WAIT: begin
        if (w_resp_load) w_next = ST_RESPOND;
        else             w_next = ST_WAIT;
      end
      ST_RESPOND: begin
        if (r_resp_valid && resp_ready) w_next = ST_IDLE;
        else                            w_next = ST_RESPOND;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Address checks, completion detection and response selection
  always_comb begin
    w_check_ok  = 1'b1;
    w_ack_done  = 1'b0;
    w_timeout   = 1'b0;
    w_issue     = 1'b0;
    w_resp_load = 1'b0;
    w_resp_ok   = 1'b0;
    w_resp_code = 8'h00;

    case (r_op)
      OP_INSTR_WR: begin
        w_check_ok = (int'(w_blk_byte) < N_BLOCKS);
        w_ack_done = instr_write_ack;
      end
      OP_REG_WR, OP_REG_UPD: begin
        w_check_ok = (int'(w_blk_byte) < N_BLOCKS) &&
                     ((w_reg_addr >> BLOCK_REG_ADDR_WIDTH) == 8'd0);
        w_ack_done = reg_write_ack;
      end
      // Full reset completes only after resetting has been high and then fallen
      OP_FRESET: w_ack_done = r_seen_high && !resetting;
      default: begin
        w_check_ok = 1'b1;
        w_ack_done = 1'b0;
      end
    endcase
    w_timeout = (r_timer == TMR_W'(ACK_TIMEOUT - 1));

    case (r_state)
      ST_IDLE: begin
        if (w_in_fire && !op_known(in_byte)) begin
          w_resp_load = 1'b1;
          w_resp_code = RESP_BAD_OP;
        end else begin
          w_resp_load = 1'b0;
        end
      end
      ST_CHECK: begin
        if (w_check_ok) begin
          w_issue = 1'b1;
        end else begin
          w_resp_load = 1'b1;
          w_resp_code = RESP_BAD_ADDR;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        if (!op_needs_ack(r_op) || w_ack_done) begin
          w_resp_load = 1'b1;
          w_resp_ok   = 1'b1;
          w_resp_code = RESP_OK_BASE | r_op;
        end else if (w_timeout) begin
          w_resp_load = 1'b1;
          w_resp_code = RESP_TIMEOUT;
        end else begin
          w_resp_load = 1'b0;
        end
      end
      default: w_resp_load = 1'b0;
    endcase
  end

  // Registered strobes, data outputs, response and bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op           <= 8'h00;
      r_timer        <= '0;
      r_seen_high    <= 1'b0;
      r_in_ready     <= 1'b1;
      r_busy         <= 1'b0;
      r_resp_valid   <= 1'b0;
      r_resp_byte    <= 8'h00;
      r_cmd_count    <= 32'd0;
      r_instr_write  <= 1'b0;
      r_reg_write    <= 1'b0;
      r_reg_update   <= 1'b0;
      r_commit       <= 1'b0;
      r_alloc        <= 1'b0;
      r_freset       <= 1'b0;
      r_block_target <= '0;
      r_reg_target   <= '0;
      r_instr_val    <= '0;
      r_ctrl_data    <= '0;
      r_delay        <= '0;
    end else begin
      if (w_in_fire && (r_state == ST_IDLE)) r_op <= in_byte;

      r_instr_write <= w_issue && (r_op == OP_INSTR_WR);
      r_reg_write   <= w_issue && ((r_op == OP_REG_WR) || (r_op == OP_REG_UPD));
      r_reg_update  <= w_issue && (r_op == OP_REG_UPD);
      r_commit      <= w_issue && (r_op == OP_COMMIT);
      r_alloc       <= w_issue && (r_op == OP_ALLOC);
      r_freset      <= w_issue && (r_op == OP_FRESET);

      r_in_ready <= (w_next == ST_IDLE) || (w_next == ST_PAYLOAD);
      r_busy     <= (w_next != ST_IDLE);

      if (w_issue) begin
        case (r_op)
          OP_INSTR_WR: begin
            r_block_target <= w_blk_byte[BLK_W-1:0];
            r_instr_val    <= w_sh[BLOCK_INSTR_WIDTH-1:0];
          end
          OP_REG_WR, OP_REG_UPD: begin
            r_block_target <= w_blk_byte[BLK_W-1:0];
            r_reg_target   <= {w_blk_byte[BLK_W-1:0], w_reg_addr[BLOCK_REG_ADDR_WIDTH-1:0]};
            r_ctrl_data    <= DATA_WIDTH'(w_sh[15:0]);
          end
          OP_ALLOC: r_delay <= (2*DATA_WIDTH)'(w_sh[31:0]);
          default:  r_delay <= r_delay;
        endcase
      end

      if (r_state == ST_CHECK) begin
        r_timer     <= '0;
        r_seen_high <= 1'b0;
      end else if ((r_state == ST_ISSUE) || (r_state == ST_WAIT)) begin
        r_timer     <= r_timer + TMR_W'(1);
        r_seen_high <= r_seen_high || resetting;
      end else begin
        r_timer     <= r_timer;
        r_seen_high <= r_seen_high;
      end

      if (w_resp_load) begin
        r_resp_valid <= 1'b1;
        r_resp_byte  <= w_resp_code;
      end else if (r_resp_valid && resp_ready) begin
        r_resp_valid <= 1'b0;
      end else begin
        r_resp_valid <= r_resp_valid;
      end

      if (w_resp_load && w_resp_ok) r_cmd_count <= r_cmd_count + 32'd1;
    end
  end

  assign in_ready          = r_in_ready;
  assign busy              = r_busy;
  assign resp_valid        = r_resp_valid;
  assign resp_byte         = r_resp_byte;
  assign cmd_count         = r_cmd_count;
  assign instr_write       = r_instr_write;
  assign reg_write         = r_reg_write;
  assign reg_update        = r_reg_update;
  assign reg_writes_commit = r_commit;
  assign alloc_delay       = r_alloc;
  assign full_reset        = r_freset;
  assign block_target      = r_block_target;
  assign reg_target        = r_reg_target;
  assign instr_val         = r_instr_val;
  assign ctrl_data         = r_ctrl_data;
  assign buf_init_delay    = r_delay;

endmodule

// File: tb/tb_pipeline_cmd_issuer.sv
// Directed self-checking bench for pipeline_cmd_issuer: framing, strobe
// timing, ack/timeout handling, error responses and mid-frame reset.
module tb_pipeline_cmd_issuer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  resp_byte;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [7:0]  block_target;
  logic [11:0] reg_target;
  logic [31:0] instr_val;
  logic [15:0] ctrl_data;
  logic [31:0] buf_init_delay;
  logic        instr_write, reg_write, reg_update, reg_writes_commit, alloc_delay, full_reset;
  logic        instr_write_ack = 1'b0;
  logic        reg_write_ack = 1'b0;
  logic        resetting = 1'b0;
  logic        busy;
  logic [31:0] cmd_count;

  int n_vec = 0;
  int n_err = 0;
  int n_regwr = 0;
  int cyc;
  int snap;

  pipeline_cmd_issuer dut (
    .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .resp_byte(resp_byte), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .block_target(block_target), .reg_target(reg_target), .instr_val(instr_val),
    .ctrl_data(ctrl_data), .buf_init_delay(buf_init_delay),
    .instr_write(instr_write), .reg_write(reg_write), .reg_update(reg_update),
    .reg_writes_commit(reg_writes_commit), .alloc_delay(alloc_delay), .full_reset(full_reset),
    .instr_write_ack(instr_write_ack), .reg_write_ack(reg_write_ack), .resetting(resetting),
    .busy(busy), .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) n_regwr <= n_regwr + (reg_write ? 1 : 0);

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; byte is accepted at the following posedge
  task automatic send_byte(input logic [7:0] b);
    in_byte  = b;
    in_valid = 1'b1;
    chk("in_ready_for_byte", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_resp(input int max, output int cycles);
    cycles = 0;
    while (!resp_valid && cycles < max) begin
      @(negedge clk);
      cycles++;
    end
    chk("resp_arrived", 64'(resp_valid), 64'd1);
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_valid_dropped", 64'(resp_valid), 64'd0);
    chk("in_ready_after_resp", 64'(in_ready), 64'd1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_byte", 64'(resp_byte), 64'h00);
    chk("rst_cmd_count", 64'(cmd_count), 64'd0);
    chk("rst_strobes", 64'({instr_write, reg_write, reg_update, reg_writes_commit, alloc_delay, full_reset}), 64'd0);
    chk("rst_data", 64'(reg_target) | 64'(instr_val) | 64'(ctrl_data) | 64'(buf_init_delay), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // INSTR_WR blk 5, instr DEADBEEF, ack in the strobe cycle
    send_byte(8'h01); send_byte(8'h05);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    chk("iw_not_yet", 64'(instr_write), 64'd0);
    chk("iw_in_ready_low", 64'(in_ready), 64'd0);
    chk("iw_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("iw_strobe", 64'(instr_write), 64'd1);
    chk("iw_block", 64'(block_target), 64'd5);
    chk("iw_instr", 64'(instr_val), 64'hDEADBEEF);
    instr_write_ack = 1'b1;
    @(negedge clk);
    instr_write_ack = 1'b0;
    chk("iw_strobe_one_cycle", 64'(instr_write), 64'd0);
    chk("iw_resp_valid", 64'(resp_valid), 64'd1);
    chk("iw_resp", 64'(resp_byte), 64'hA1);
    handshake();
    chk("iw_count", 64'(cmd_count), 64'd1);

    // REG_WR blk 3 reg 2 data ABCD, ack 4 cycles after strobe
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h02); send_byte(8'hAB); send_byte(8'hCD);
    @(negedge clk);
    chk("rw_strobe", 64'(reg_write), 64'd1);
    chk("rw_no_update", 64'(reg_update), 64'd0);
    chk("rw_target", 64'(reg_target), 64'h032);
    chk("rw_data", 64'(ctrl_data), 64'hABCD);
    @(negedge clk);
    chk("rw_strobe_one_cycle", 64'(reg_write), 64'd0);
    repeat (2) @(negedge clk);
    chk("rw_no_early_resp", 64'(resp_valid), 64'd0);
    reg_write_ack = 1'b1;
    @(negedge clk);
    reg_write_ack = 1'b0;
    wait_resp(5, cyc);
    chk("rw_resp", 64'(resp_byte), 64'hA2);
    handshake();
    chk("rw_count", 64'(cmd_count), 64'd2);

    // REG_WR with no ack: timeout after 1023 waiting cycles
    snap = n_regwr;
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h02); send_byte(8'h00); send_byte(8'h01);
    wait_resp(1100, cyc);
    chk("to_latency", 64'(cyc), 64'd1024);
    chk("to_resp", 64'(resp_byte), 64'hE2);
    chk("to_single_strobe", 64'(n_regwr - snap), 64'd1);
    handshake();
    chk("to_count_unchanged", 64'(cmd_count), 64'd2);

    // Unknown opcode, then COMMIT
    send_byte(8'h7F);
    chk("bad_op_valid", 64'(resp_valid), 64'd1);
    chk("bad_op_resp", 64'(resp_byte), 64'hE0);
    chk("bad_op_in_ready", 64'(in_ready), 64'd0);
    handshake();
    send_byte(8'h04);
    chk("cm_not_yet", 64'(reg_writes_commit), 64'd0);
    @(negedge clk);
    chk("cm_strobe", 64'(reg_writes_commit), 64'd1);
    @(negedge clk);
    chk("cm_strobe_one_cycle", 64'(reg_writes_commit), 64'd0);
    chk("cm_resp_valid", 64'(resp_valid), 64'd1);
    chk("cm_resp", 64'(resp_byte), 64'hA4);
    handshake();
    chk("cm_count", 64'(cmd_count), 64'd3);

    // FRESET: resetting high 3 cycles then low; host stalls the response
    send_byte(8'h06);
    @(negedge clk);
    chk("fr_strobe", 64'(full_reset), 64'd1);
    resetting = 1'b1;
    repeat (3) @(negedge clk);
    chk("fr_waiting", 64'(resp_valid), 64'd0);
    resetting = 1'b0;
    wait_resp(5, cyc);
    for (int i = 0; i < 10; i++) begin
      chk("fr_resp_hold", 64'(resp_byte), 64'hA6);
      chk("fr_in_ready_hold", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    chk("fr_still_valid", 64'(resp_valid), 64'd1);
    handshake();
    chk("fr_count", 64'(cmd_count), 64'd4);

    // REG_UPD with ack in the strobe cycle
    send_byte(8'h03); send_byte(8'h07); send_byte(8'h0F); send_byte(8'h12); send_byte(8'h34);
    @(negedge clk);
    chk("ru_strobes", 64'({reg_write, reg_update}), 64'd3);
    chk("ru_target", 64'(reg_target), 64'h07F);
    chk("ru_data", 64'(ctrl_data), 64'h1234);
    reg_write_ack = 1'b1;
    @(negedge clk);
    reg_write_ack = 1'b0;
    chk("ru_resp", 64'(resp_byte), 64'hA3);
    handshake();

    // Register byte with bits above the reg field set: rejected, no strobe
    snap = n_regwr;
    send_byte(8'h02); send_byte(8'h01); send_byte(8'h12); send_byte(8'h00); send_byte(8'h00);
    wait_resp(4, cyc);
    chk("e1_resp", 64'(resp_byte), 64'hE1);
    chk("e1_no_strobe", 64'(n_regwr - snap), 64'd0);
    chk("e1_data_kept", 64'(ctrl_data), 64'h1234);
    handshake();
    chk("e1_count", 64'(cmd_count), 64'd5);

    // Reset mid ALLOC frame, then a full ALLOC
    send_byte(8'h05); send_byte(8'h00); send_byte(8'h00);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_no_alloc", 64'(alloc_delay), 64'd0);
    chk("mr_no_resp", 64'(resp_valid), 64'd0);
    chk("mr_idle", 64'({busy, in_ready}), 64'd1);
    chk("mr_count_cleared", 64'(cmd_count), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    send_byte(8'h05); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
    @(negedge clk);
    chk("al_strobe", 64'(alloc_delay), 64'd1);
    chk("al_delay", 64'(buf_init_delay), 64'h100);
    @(negedge clk);
    chk("al_strobe_one_cycle", 64'(alloc_delay), 64'd0);
    chk("al_resp", 64'(resp_byte), 64'hA5);
    handshake();
    chk("al_count", 64'(cmd_count), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
